// File: rtl/cpu_pkg.sv
// Shared opcode encodings, FSM state type and opcode-class helpers for the
// parametrised accumulator CPU.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADC  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_SWAB = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_LDX  = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_STX  = 4'h9;
  localparam logic [3:0] OP_SWAC = 4'hA;
  localparam logic [3:0] OP_JEQ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_NOT  = 4'hD;
  localparam logic [3:0] OP_AND  = 4'hE;
  localparam logic [3:0] OP_OR   = 4'hF;

  typedef enum logic [1:0] {FETCH, OPERAND, EXEC, MEM} state_t;

  // Opcodes that carry an operand word after the opcode word.
  function automatic logic is_two_word(input logic [3:0] opcode);
    return ((opcode >= OP_LDI) && (opcode <= OP_STX)) ||
           (opcode == OP_JEQ) || (opcode == OP_JMP);
  endfunction

  // Opcodes that need a data-memory transaction after the operand.
  function automatic logic is_mem_op(input logic [3:0] opcode);
    return (opcode >= OP_LD) && (opcode <= OP_STX);
  endfunction

  function automatic logic is_store(input logic [3:0] opcode);
    return (opcode == OP_ST) || (opcode == OP_STX);
  endfunction

  function automatic logic is_indexed(input logic [3:0] opcode);
    return (opcode == OP_LDX) || (opcode == OP_STX);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: arithmetic with carry, bitwise ops. Opcodes it does not
// own pass A and CF through unchanged.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cf,
  output logic [DATA_W-1:0] new_a,
  output logic              new_cf
);

  logic [DATA_W-1:0] b_op;
  logic              carry_in;
  logic [DATA_W:0]   sum;

  // One shared adder: subtracts invert B, carry-in selects ADD/SUB/ADC/SBC.
  always_comb begin
    b_op = ((opcode == OP_SUB) || (opcode == OP_SBC)) ? ~b : b;
    case (opcode)
      OP_SUB:         carry_in = 1'b1;
      OP_ADC, OP_SBC: carry_in = cf;
      default:        carry_in = 1'b0;
    endcase
    sum = {1'b0, a} + {1'b0, b_op} + {{DATA_W{1'b0}}, carry_in};
  end

  // Result select; CF only changes on the four arithmetic opcodes.
  always_comb begin
    new_a  = a;
    new_cf = cf;
    case (opcode)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: {new_cf, new_a} = sum;
      OP_NOT:  new_a = ~a;
      OP_AND:  new_a = a & b;
      OP_OR:   new_a = a | b;
      default: new_a = a;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// Accumulator CPU core: FETCH/OPERAND/EXEC/MEM sequencer, register file,
// instruction pointer and registered req/ready bus master outputs.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] busAddr,
  output logic [DATA_W-1:0] busWData,
  input  logic [DATA_W-1:0] busRData,
  output logic              busReq,
  output logic              busWrite,
  input  logic              busReady,
  output logic              sync
);

  localparam int T_W = 2*DATA_W - 4;

  state_t            state;
  logic [DATA_W-1:0] a, b, c, ir, opr;
  logic [ADDR_W-1:0] ip;
  logic              cf;

  logic [DATA_W-1:0] alu_a;
  logic              alu_cf;

  logic [3:0]        opcode, fetch_op;
  logic [T_W-1:0]    c_ext, tgt_bus, tgt_reg, eff_full;
  logic [ADDR_W-1:0] mem_addr, jump_addr, ip_inc, exec_ip;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .cf     (cf),
    .new_a  (alu_a),
    .new_cf (alu_cf)
  );

  // Address arithmetic; the data address uses the operand arriving on the bus
  // so MEM can be requested on the same edge the operand completes.
  always_comb begin
    opcode    = ir[DATA_W-1:DATA_W-4];
    fetch_op  = busRData[DATA_W-1:DATA_W-4];
    c_ext     = {{(T_W-DATA_W){1'b0}}, c};
    tgt_bus   = {ir[DATA_W-5:0], busRData};
    tgt_reg   = {ir[DATA_W-5:0], opr};
    eff_full  = is_indexed(opcode) ? (tgt_bus + c_ext) : tgt_bus;
    mem_addr  = eff_full[ADDR_W-1:0];
    jump_addr = tgt_reg[ADDR_W-1:0];
    ip_inc    = ip + ADDR_W'(1);
    exec_ip   = ((opcode == OP_JMP) || ((opcode == OP_JEQ) && (a == b))) ? jump_addr : ip;
  end

  // Sequencer: every bus output is registered and everything holds while a request waits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FETCH;
      a        <= '0;
      b        <= '0;
      c        <= '0;
      ir       <= '0;
      opr      <= '0;
      ip       <= '0;
      cf       <= 1'b0;
      busAddr  <= '0;
      busWData <= '0;
      busReq   <= 1'b0;
      busWrite <= 1'b0;
      sync     <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (!busReq) begin
            busReq   <= 1'b1;
            busWrite <= 1'b0;
            sync     <= 1'b1;
            busAddr  <= ip;
          end else if (busReady) begin
            ir   <= busRData;
            ip   <= ip_inc;
            sync <= 1'b0;
            if (is_two_word(fetch_op)) begin
              state   <= OPERAND;
              busAddr <= ip_inc;
            end else begin
              state  <= EXEC;
              busReq <= 1'b0;
            end
          end
        end
        OPERAND: begin
          if (busReady) begin
            opr <= busRData;
            ip  <= ip_inc;
            if (is_mem_op(opcode)) begin
              state    <= MEM;
              busAddr  <= mem_addr;
              busWrite <= is_store(opcode);
              busWData <= is_store(opcode) ? a : '0;
            end else begin
              state  <= EXEC;
              busReq <= 1'b0;
            end
          end
        end
        EXEC: begin
          case (opcode)
            OP_SWAB: begin
              a <= b;
              b <= a;
            end
            OP_SWAC: begin
              a <= c;
              c <= a;
            end
            OP_LDI: a <= opr;
            OP_JEQ, OP_JMP: begin
            end
            default: begin
              a  <= alu_a;
              cf <= alu_cf;
            end
          endcase
          ip      <= exec_ip;
          busAddr <= exec_ip;
          busReq  <= 1'b1;
          sync    <= 1'b1;
          state   <= FETCH;
        end
        MEM: begin
          if (busReady) begin
            if (!busWrite) a <= busRData;
            busWrite <= 1'b0;
            busWData <= '0;
            busAddr  <= ip;
            sync     <= 1'b1;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
